// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: default widths,
// port indices and the grant-select encoding used between top and picker.
package dm_arb_pkg;

  localparam int ADDR_W_DEF   = 7;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 4;

  localparam int NUM_PORTS = 2;
  localparam int PORT_CPU  = 0;
  localparam int PORT_DMA  = 1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_DMA  = 2'b10
  } gnt_sel_e;

endpackage

// File: rtl/dm_arb_pick.sv
// Two-way grant decision: a starving port wins outright (CPU first on a tie),
// otherwise the preference supplied by the top-level policy breaks the tie.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  logic     starve0,
  input  logic     starve1,
  input  logic     prefer_dma,
  output gnt_sel_e sel
);

  // NOTE: every output of an always_comb gets a default first so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    sel = GNT_NONE;
    if (req0 && req1) begin
      if (starve0) begin
        sel = GNT_CPU;
      end else if (starve1) begin
        sel = GNT_DMA;
      end else begin
        sel = prefer_dma ? GNT_DMA : GNT_CPU;
      end
    end else if (req0) begin
      sel = GNT_CPU;
    end else if (req1) begin
      sel = GNT_DMA;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port data memory.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed CPU priority.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [NUM_PORTS-1:0] req_act;
  logic [NUM_PORTS-1:0] we_in;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] starve;
  logic [ADDR_W-1:0]    addr_in  [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_in [NUM_PORTS];

  logic [CNT_W-1:0]     wait_q   [NUM_PORTS];
  logic [CNT_W-1:0]     wait_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] rvalid_q;
  logic [NUM_PORTS-1:0] rvalid_d;
  logic [DATA_W-1:0]    rdata_q  [NUM_PORTS];
  logic [DATA_W-1:0]    rdata_d  [NUM_PORTS];

  logic     prefer_dma;
  gnt_sel_e sel;

  // Requests are masked while reset is high so nothing is granted or stalled.
  always_comb begin
    req_act            = {p1_req, p0_req} & {NUM_PORTS{~rst}};
    we_in              = {p1_we, p0_we};
    addr_in[PORT_CPU]  = p0_addr;
    addr_in[PORT_DMA]  = p1_addr;
    wdata_in[PORT_CPU] = p0_wdata;
    wdata_in[PORT_DMA] = p1_wdata;
  end

`ifdef ARB_RR_EN
  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (sel == GNT_CPU) begin
      last_d = 1'(PORT_CPU);
    end else if (sel == GNT_DMA) begin
      last_d = 1'(PORT_DMA);
    end
  end

  // Pointer starts at DMA so the first contested grant after reset goes to CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'(PORT_DMA);
    end else begin
      last_q <= last_d;
    end
  end

  assign prefer_dma = (last_q == 1'(PORT_CPU));
`else
  assign prefer_dma = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      starve[i] = (wait_q[i] == WAIT_MAX);
    end
  end

  dm_arb_pick u_pick (
    .req0       (req_act[PORT_CPU]),
    .req1       (req_act[PORT_DMA]),
    .starve0    (starve[PORT_CPU]),
    .starve1    (starve[PORT_DMA]),
    .prefer_dma (prefer_dma),
    .sel        (sel)
  );

  always_comb begin
    gnt           = '0;
    gnt[PORT_CPU] = (sel == GNT_CPU);
    gnt[PORT_DMA] = (sel == GNT_DMA);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (sel)
      GNT_CPU: begin
        mem_en    = 1'b1;
        mem_we    = we_in[PORT_CPU];
        mem_addr  = addr_in[PORT_CPU];
        mem_wdata = wdata_in[PORT_CPU];
      end
      GNT_DMA: begin
        mem_en    = 1'b1;
        mem_we    = we_in[PORT_DMA];
        mem_addr  = addr_in[PORT_DMA];
        mem_wdata = wdata_in[PORT_DMA];
      end
      default: ;
    endcase
  end

  // Read data is forwarded straight from memory in the rvalid cycle and then
  // held, so the port sees it without an extra register stage.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      wait_d[i] = '0;
      if (req_act[i] && !gnt[i]) begin
        wait_d[i] = (wait_q[i] == WAIT_MAX) ? WAIT_MAX : wait_q[i] + 1'b1;
      end
      rvalid_d[i] = gnt[i] & ~we_in[i];
      rdata_d[i]  = rvalid_q[i] ? mem_rdata : rdata_q[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wait_q[i]  <= '0;
        rdata_q[i] <= '0;
      end
      rvalid_q <= '0;
    end else begin
      wait_q   <= wait_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign p0_gnt    = gnt[PORT_CPU];
  assign p1_gnt    = gnt[PORT_DMA];
  assign p0_stall  = req_act[PORT_CPU] & ~gnt[PORT_CPU];
  assign p1_stall  = req_act[PORT_DMA] & ~gnt[PORT_DMA];
  assign p0_rvalid = rvalid_q[PORT_CPU];
  assign p1_rvalid = rvalid_q[PORT_DMA];
  assign p0_rdata  = rdata_d[PORT_CPU];
  assign p1_rdata  = rdata_d[PORT_DMA];

endmodule
